// File: rtl/rom_fetch_if.sv
// Fetch-unit bundle: control inputs, ROM bus and instruction stream.
// master = fetch unit side, slave = environment (ROM + consumer + controller).
interface rom_fetch_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5
);
    logic             enable;
    logic             jump;
    logic [DEPTH-1:0] jump_addr;
    logic [DEPTH-1:0] rom_addr;
    logic             rom_cs;
    logic             rom_oe;
    logic [WIDTH-1:0] rom_data;
    logic [WIDTH-1:0] instr;
    logic             instr_valid;
    logic             instr_ready;
    logic [DEPTH-1:0] pc;

    modport master (
        input  enable, jump, jump_addr, rom_data, instr_ready,
        output rom_addr, rom_cs, rom_oe, instr, instr_valid, pc
    );

    modport slave (
        output enable, jump, jump_addr, rom_data, instr_ready,
        input  rom_addr, rom_cs, rom_oe, instr, instr_valid, pc
    );
endinterface

// File: rtl/rom_fetch.sv
// Sequential ROM instruction fetcher with a small in-order instruction buffer.
// Define ROM_FETCH_PREFETCH_EN for a 2-entry buffer (one word/cycle); default is 1 entry.
module rom_fetch #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5
) (
    input  logic      clk,
    input  logic      rst,
    rom_fetch_if.master bus
);

`ifdef ROM_FETCH_PREFETCH_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] BUF_FULL = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [DEPTH-1:0] pc_reg, pc_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] count_after_pop;
    logic [WIDTH-1:0] buf_reg  [BUF_DEPTH];
    logic [WIDTH-1:0] buf_next [BUF_DEPTH];
    logic             push;
    logic             pop;

    // A jump discards everything in flight: no pop, no capture, buffer emptied.
    always_comb begin
        pop  = (count_reg != '0) && bus.instr_ready && !bus.jump;
        push = (state_reg == FETCH) && !bus.jump && ((count_reg < BUF_FULL) || pop);
        count_after_pop = count_reg - CNT_W'(pop);
    end

    // Buffer is kept head-aligned: entry 0 is always the oldest word.
    always_comb begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_next[i] = buf_reg[i];
        end
        if (pop) begin
            for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                buf_next[i] = buf_reg[i + 1];
            end
            buf_next[BUF_DEPTH - 1] = '0;
        end
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (push && (CNT_W'(i) == count_after_pop)) begin
                buf_next[i] = bus.rom_data;
            end
        end
    end

    always_comb begin
        count_next = count_after_pop + CNT_W'(push);
        pc_next    = pc_reg + {{(DEPTH-1){1'b0}}, push};
        state_next = state_reg;
        if (bus.jump) begin
            count_next = '0;
            pc_next    = bus.jump_addr;
            state_next = bus.enable ? FETCH : IDLE;
        end else if (!bus.enable) begin
            state_next = IDLE;
        end else if (count_next < BUF_FULL) begin
            state_next = FETCH;
        end else begin
            // Resuming with a full retained buffer parks in WAIT rather than overfilling.
            state_next = WAIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            count_reg <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            count_reg <= count_next;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_reg[i] <= buf_next[i];
            end
        end
    end

    assign bus.rom_cs      = (state_reg != FETCH);
    assign bus.rom_oe      = (state_reg == FETCH);
    assign bus.rom_addr    = pc_reg;
    assign bus.pc          = pc_reg;
    assign bus.instr       = buf_reg[0];
    assign bus.instr_valid = (count_reg != '0);

endmodule
